// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: pops one byte per frame, strobes tx_start,
// follows tx_busy through the frame and flags overflow / busy-acknowledge timeout.
module uart_tx_feeder #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int GAP_CYCLES   = 0,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              timeout_err,
    input  logic              clr_flags,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy
);
    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [7:0]       TMO_LAST = 8'(BUSY_TIMEOUT - 1);
    localparam logic [ADDR_W:0]  LVL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]  LVL_ONE  = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {IDLE, STROBE, WAIT_BUSY, WAIT_DONE, GAP} state_t;
    state_t state, state_nxt;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   level_nxt;
    logic [7:0]        tmo_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              push, pop, tmo_hit;

    // full is the registered flag, so a write while full is dropped even if a pop happens now
    assign push = wr_en & ~full;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx_start  = 1'b0;
        tmo_hit   = 1'b0;
        unique case (state)
            IDLE: begin
                // busy guard also covers a transmitter still mid-frame after our reset
                if (!empty && !tx_busy) begin
                    pop       = 1'b1;
                    state_nxt = STROBE;
                end
            end
            STROBE: begin
                tx_start  = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (gap_cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        level_nxt = level;
        if (push && !pop)      level_nxt = level + LVL_ONE;
        else if (pop && !push) level_nxt = level - LVL_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
            tx_data     <= 8'h00;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop) begin
                tx_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + ADDR_W'(1);
            end
            level <= level_nxt;
            full  <= (level_nxt == LVL_FULL);
            empty <= (level_nxt == '0);

            if (wr_en && full)  overflow <= 1'b1;
            else if (clr_flags) overflow <= 1'b0;
            if (tmo_hit)        timeout_err <= 1'b1;
            else if (clr_flags) timeout_err <= 1'b0;

            if (state == STROBE)         tmo_cnt <= '0;
            else if (state == WAIT_BUSY) tmo_cnt <= tmo_cnt + 8'd1;
            if (state == WAIT_DONE)      gap_cnt <= GAP_INIT;
            else if (state == GAP)       gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Two feeders (no gap / 4-cycle gap) share the host side; each gets its own
// transmitter model and a frame-level timing model of when strobes must appear.
module tb_uart_tx_feeder;
    localparam int DEPTH = 16;
    localparam int BT    = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr_flags = 1'b0;
    logic [1:0] tx_busy = 2'b00;
    logic [1:0] full, empty, overflow, timeout_err, tx_start;
    logic [4:0] level [2];
    logic [7:0] tx_data [2];

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(16), .ADDR_W(4), .GAP_CYCLES(0), .BUSY_TIMEOUT(BT)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full[0]), .empty(empty[0]), .level(level[0]),
        .overflow(overflow[0]), .timeout_err(timeout_err[0]), .clr_flags(clr_flags),
        .tx_start(tx_start[0]), .tx_data(tx_data[0]), .tx_busy(tx_busy[0]));

    uart_tx_feeder #(.DEPTH(16), .ADDR_W(4), .GAP_CYCLES(4), .BUSY_TIMEOUT(BT)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full[1]), .empty(empty[1]), .level(level[1]),
        .overflow(overflow[1]), .timeout_err(timeout_err[1]), .clr_flags(clr_flags),
        .tx_start(tx_start[1]), .tx_data(tx_data[1]), .tx_busy(tx_busy[1]));

    int n_chk = 0, n_err = 0, cyc = 0;
    int force_len = 0, dead_pct = 0;
    bit dead_all = 0;

    // model: pending bytes (data, first cycle visible in level), feeder/transmitter timing
    logic [7:0] qd [2][64];
    int         qa [2][64];
    int         qh [2], qt [2];
    int         ready [2], bst [2], bend [2], tcyc [2];
    logic       ov [2], tmo [2], strb [2];
    logic [7:0] last [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int pick_len();
        if (force_len > 0) return force_len;
        if (dead_all) return 0;
        if (dead_pct > 0 && $urandom_range(99) < dead_pct) return 0;
        return $urandom_range(12, 1);
    endfunction

    // advance model i to cycle cyc given the inputs applied during cyc-1
    task automatic model(input int i, input logic we, input logic [7:0] wd, input logic clr, input logic rs);
        int sz, p, len;
        sz = qt[i] - qh[i];
        strb[i] = 1'b0;
        if (rs) begin
            qh[i] = 0; qt[i] = 0; ready[i] = cyc; tcyc[i] = -1;
            ov[i] = 1'b0; tmo[i] = 1'b0; last[i] = 8'h00;
        end else begin
            if (we && sz == DEPTH) ov[i] = 1'b1;
            else if (clr)          ov[i] = 1'b0;
            if (cyc == tcyc[i])    tmo[i] = 1'b1;
            else if (clr)          tmo[i] = 1'b0;
            if (sz > 0) begin
                // idle cycle in which the pop happens; strobe follows one cycle later
                p = max3(ready[i], qa[i][qh[i] % 64], bend[i] + 1);
                if (p + 1 == cyc) begin
                    strb[i] = 1'b1;
                    last[i] = qd[i][qh[i] % 64];
                    qh[i]++;
                    len = pick_len();
                    if (len == 0) begin
                        ready[i] = cyc + BT + 1;
                        tcyc[i]  = cyc + BT + 1;
                    end else begin
                        bst[i]   = cyc + 1;
                        bend[i]  = cyc + len;
                        ready[i] = cyc + len + 2 + ((i == 0) ? 0 : 4);
                    end
                end
            end
            if (we && sz != DEPTH) begin
                qd[i][qt[i] % 64] = wd;
                qa[i][qt[i] % 64] = cyc;
                qt[i]++;
            end
        end
    endtask

    task automatic step(input logic we, input logic [7:0] wd, input logic clr, input logic rs);
        int sz;
        wr_en = we; wr_data = wd; clr_flags = clr; rst = rs;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            model(i, we, wd, clr, rs);
            sz = qt[i] - qh[i];
            chk($sformatf("level%0d", i), level[i], sz);
            chk($sformatf("full%0d", i), full[i], sz == DEPTH);
            chk($sformatf("empty%0d", i), empty[i], sz == 0);
            chk($sformatf("ovf%0d", i), overflow[i], ov[i]);
            chk($sformatf("tmo%0d", i), timeout_err[i], tmo[i]);
            chk($sformatf("start%0d", i), tx_start[i], strb[i]);
            chk($sformatf("data%0d", i), tx_data[i], last[i]);
        end
        for (int i = 0; i < 2; i++) tx_busy[i] = (cyc >= bst[i]) && (cyc <= bend[i]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            qh[i] = 0; qt[i] = 0; ready[i] = 0; bst[i] = 0; bend[i] = -1; tcyc[i] = -1;
            ov[i] = 1'b0; tmo[i] = 1'b0; strb[i] = 1'b0; last[i] = 8'h00;
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(2);

        // single byte, long frame
        force_len = 20;
        wr(8'hA5);
        idle(35);

        // burst of three
        force_len = 0;
        wr(8'h11); wr(8'h22); wr(8'h33);
        idle(60);

        // fill while transmitter busy: 16 kept, 17th dropped
        force_len = 50;
        wr(8'hC0);
        idle(3);
        for (int k = 0; k < 17; k++) wr(8'(k));
        force_len = 0;
        idle(10);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle(330);

        // transmitter never answers
        dead_all = 1;
        wr(8'h5A);
        idle(14);
        dead_all = 0;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        idle(3);

        // two queued bytes exercise the gap spacing
        force_len = 5;
        wr(8'h71); wr(8'h72);
        idle(30);

        // reset mid-frame with bytes queued and transmitter still busy
        force_len = 40;
        for (int k = 0; k < 6; k++) wr(8'h80 + 8'(k));
        idle(8);
        force_len = 0;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(45);
        wr(8'h9E);
        idle(30);

        // random traffic, flag clears and occasional dead frames
        dead_pct = 8;
        for (int k = 0; k < 800; k++)
            step($urandom_range(99) < 35, 8'($urandom), $urandom_range(99) < 4, 1'b0);
        idle(450);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
